uart_tx_scheduler: RTL and testbench

//  Round-robin scheduler sharing the single UART transmitter between NUM_REQ byte sources
//  (rx echo/ack, loader status, memory readback). Accepts one byte per grant over a

---
 rtl/uart_tx_scheduler.sv | 128 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources,
// with a tx_done watchdog that aborts stalled transfers and raises a sticky error.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*BYTE_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [BYTE_WIDTH-1:0]         tx_data,
  output logic                          tx_start,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          err_timeout,
  input  logic                          err_clr
);
  localparam int unsigned ID_W     = $clog2(NUM_REQ);
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ID_W-1:0]         r_last;
  logic [ID_W-1:0]         r_grant;
  logic [BYTE_WIDTH-1:0]   r_tx_data;
  logic                    r_tx_start;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;

  logic [NUM_REQ-1:0]      w_above;
  logic [NUM_REQ-1:0]      w_cand;
  logic [ID_W-1:0]         w_win;
  logic                    w_any;
  logic [BYTE_WIDTH-1:0]   w_byte;
  logic                    w_accept;
  logic                    w_timeout;

  // Rotating priority: lowest valid index above the last grant, else lowest valid overall.
  always_comb begin
    w_above = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (i > int'(r_last)) w_above[i] = 1'b1;
    end
    w_cand = ((req_valid & w_above) != '0) ? (req_valid & w_above) : req_valid;
    w_any  = |req_valid;
    w_win  = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (w_cand[i]) w_win = ID_W'(i);
    end
  end

  always_comb begin
    w_byte = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_win == ID_W'(i)) w_byte = req_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    req_ready   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any && arst_n) begin
          req_ready[w_win] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = S_START;
        end
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          w_state_nxt = S_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TMO_LAST))) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Datapath, pointer, watchdog counter and sticky error.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_last     <= ID_W'(NUM_REQ - 1);
      r_grant    <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_tx_start <= w_accept;
      if (w_accept) begin
        r_tx_data <= w_byte;
        r_grant   <= w_win;
        r_last    <= w_win;
      end
      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT) && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign grant_id    = r_grant;
  assign err_timeout = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the scheduler.
module tb_uart_tx_scheduler;
  localparam int unsigned N   = 2;
  localparam int unsigned BW  = 8;
  localparam int unsigned TMO = 16;

  logic            clk = 1'b0;
  logic            arst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*BW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [BW-1:0]   tx_data;
  logic            tx_start;
  logic            tx_done = 1'b0;
  logic            busy;
  logic [0:0]      grant_id;
  logic            err_timeout;
  logic            err_clr = 1'b0;

  uart_tx_scheduler #(.NUM_REQ(N), .BYTE_WIDTH(BW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;

  // Model: one byte in flight at a time; a just-accepted byte spends one cycle starting.
  int            m_last;
  bit            m_busy;
  bit            m_starting;
  int            m_waited;
  bit            m_err;
  logic [BW-1:0] m_data;
  int            m_gid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= int'(N); k++) begin
      int idx = (last + k) % int'(N);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = int'(N) - 1; m_busy = 0; m_starting = 0; m_waited = 0;
    m_err = 0; m_data = '0; m_gid = 0;
  endtask

  // One clock cycle: drive after the falling edge, compare, then advance the model.
  task automatic cycle(input logic [N-1:0] v, input logic [N*BW-1:0] d,
                       input logic done, input logic clr, output int acc);
    int  win;
    bit  set_err;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    req_valid = v; req_data = d; tx_done = done; err_clr = clr;
    #1;
    win = m_busy ? -1 : rr_pick(v, m_last);
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("tx_start", 32'(tx_start), 32'(m_starting));
    check("busy", 32'(busy), 32'(m_busy));
    check("err_timeout", 32'(err_timeout), 32'(m_err));
    check("tx_data", 32'(tx_data), 32'(m_data));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    if (tx_start === 1'b1) n_starts++;
    acc = win;
    set_err = 0;
    if (win >= 0) begin
      m_busy = 1; m_starting = 1; m_data = d[win*BW +: BW]; m_gid = win; m_last = win;
    end else if (m_starting) begin
      m_starting = 0; m_waited = 0;
    end else if (m_busy) begin
      m_waited++;
      if (done) m_busy = 0;
      else if (m_waited == int'(TMO)) begin m_busy = 0; set_err = 1; end
    end
    if (set_err) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must drop without waiting for a clock.
  task automatic async_reset();
    arst_n = 1'b0;
    req_valid = '1;
    #1;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    arst_n = 1'b1;
  endtask

  initial begin
    int acc;
    int s0;
    int gids[4];
    logic [N-1:0]  pend;
    logic [N*BW-1:0] pdat;

    model_reset();
    // 1: reset held with both requesters valid
    req_valid = 2'b11;
    #1 arst_n = 1'b0;
    #12;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err_timeout), 32'd0);
    @(negedge clk);
    req_valid = '0;
    arst_n = 1'b1;

    // 2: single byte from requester 1, done 12 cycles into the transfer
    cycle(2'b10, {8'hA5, 8'h00}, 0, 0, acc);
    check("single_accept", 32'(acc), 32'd1);
    cycle(2'b00, '0, 0, 0, acc);
    check("single_start", 32'(tx_start), 32'd1);
    check("single_data", 32'(tx_data), 32'hA5);
    check("single_gid", 32'(grant_id), 32'd1);
    repeat (10) cycle(2'b00, '0, 0, 0, acc);
    cycle(2'b00, '0, 1, 0, acc);
    cycle(2'b00, '0, 0, 0, acc);
    check("single_idle", 32'(busy), 32'd0);

    // 3: round robin from fresh reset, both requesters always valid
    @(negedge clk); #2; async_reset();
    s0 = n_starts;
    for (int k = 0; k < 4; k++) begin
      cycle(2'b11, {8'h22, 8'h11}, 0, 0, acc);
      cycle(2'b11, {8'h22, 8'h11}, 0, 0, acc);
      gids[k] = int'(grant_id);
      check("rr_data", 32'(tx_data), (k % 2 == 0) ? 32'h11 : 32'h22);
      cycle(2'b11, {8'h22, 8'h11}, 0, 0, acc);
      cycle(2'b11, {8'h22, 8'h11}, 1, 0, acc);
    end
    for (int k = 0; k < 4; k++) check("rr_order", 32'(gids[k]), 32'(k % 2));
    check("rr_starts", 32'(n_starts - s0), 32'd4);

    // 4: watchdog expiry, clear, then done on the last allowed cycle
    cycle(2'b01, {8'h00, 8'h3C}, 0, 0, acc);
    cycle(2'b00, '0, 0, 0, acc);
    repeat (TMO) cycle(2'b00, '0, 0, 0, acc);
    cycle(2'b00, '0, 0, 0, acc);
    check("wd_err_set", 32'(err_timeout), 32'd1);
    check("wd_idle", 32'(busy), 32'd0);
    cycle(2'b00, '0, 0, 1, acc);
    cycle(2'b00, '0, 0, 0, acc);
    check("wd_err_clr", 32'(err_timeout), 32'd0);
    cycle(2'b10, {8'h5A, 8'h00}, 0, 0, acc);
    cycle(2'b00, '0, 0, 0, acc);
    repeat (TMO - 1) cycle(2'b00, '0, 0, 0, acc);
    cycle(2'b00, '0, 1, 0, acc);
    cycle(2'b00, '0, 0, 0, acc);
    check("wd_done_wins", 32'(err_timeout), 32'd0);

    // 5: stray tx_done in IDLE and START
    cycle(2'b00, '0, 1, 0, acc);
    check("stray_idle", 32'(busy), 32'd0);
    cycle(2'b01, {8'h00, 8'h77}, 1, 0, acc);
    cycle(2'b00, '0, 1, 0, acc);
    cycle(2'b00, '0, 0, 0, acc);
    check("stray_start", 32'(busy), 32'd1);
    cycle(2'b00, '0, 1, 0, acc);

    // 6: reset in WAIT after requester 0 won; pointer restarts so 0 wins again
    cycle(2'b01, {8'h00, 8'h44}, 0, 0, acc);
    cycle(2'b00, '0, 0, 0, acc);
    cycle(2'b00, '0, 0, 0, acc);
    #2; async_reset();
    cycle(2'b11, {8'h99, 8'h88}, 0, 0, acc);
    check("rst_ptr", 32'(req_ready), 32'd1);
    cycle(2'b00, '0, 0, 0, acc);
    cycle(2'b00, '0, 1, 0, acc);

    // Reset mid-START: tx_start must fall asynchronously
    cycle(2'b10, {8'hC3, 8'h00}, 0, 0, acc);
    @(posedge clk); #2;
    check("start_before_rst", 32'(tx_start), 32'd1);
    async_reset();

    // Random traffic: requesters hold bytes until accepted, occasionally withdraw
    pend = '0; pdat = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!pend[i] && ($urandom_range(2) == 0)) begin
          pend[i] = 1'b1;
          pdat[i*BW +: BW] = BW'($urandom);
        end else if (pend[i] && ($urandom_range(39) == 0)) begin
          pend[i] = 1'b0;
        end
      end
      cycle(pend, pdat, ($urandom_range(9) == 0), ($urandom_range(19) == 0), acc);
      if (acc >= 0) pend[acc] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
